dsi_hs_lane_rx: RTL and testbench

//  Receive side of one MIPI D-PHY HS data lane.
//  - Takes raw parallel bytes from the lane deserializer, waits out HS settle, then searches for the 8-bit
//    SoT sync leader at any bit offset.
//  - After sync: locks the offset and emits aligned payload bytes.
//  - Strips trailing HS-trail bytes when the LP detector reports end of HS burst.
//  - Feeds the DSI packet decoder.

---
 rtl/dsi_phy_pkg.sv | 27 ++
 rtl/dsi_rx_byte_aligner.sv | 77 +++++++
 rtl/dsi_hs_lane_rx.sv | 150 +++++++++++++++
 tb/tb_dsi_hs_lane_rx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_phy_pkg.sv
// Shared D-PHY definitions: SoT sync leader, RX lane states and sync-candidate helpers.
package dsi_phy_pkg;

    localparam logic [7:0] SYNC_PATTERN = 8'b0001_1101;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SEARCH,
        ACTIVE,
        ERR_WAIT
    } rx_state_t;

    // Candidate at offset k is win[15-k -: 8]; bit 15 is the earliest bit on the wire.
    function automatic logic [7:0] sync_cand(input logic [15:0] win, input logic [2:0] k);
        return 8'(win >> (4'd8 - 4'(k)));
    endfunction

    function automatic logic sync_match(input logic [15:0] win, input logic [2:0] k);
        return sync_cand(win, k) == SYNC_PATTERN;
    endfunction

    function automatic logic sync_near(input logic [15:0] win, input logic [2:0] k);
        return $countones(sync_cand(win, k) ^ SYNC_PATTERN) == 1;
    endfunction

endpackage

// File: rtl/dsi_rx_byte_aligner.sv
// Two-byte sliding window, SoT leader search over 8 bit offsets and aligned-byte mux.
// DSI_RX_SYNC_TOL_EN adds single-bit-error leader acceptance (found_corr).
module dsi_rx_byte_aligner
    import dsi_phy_pkg::*;
(
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [7:0] ser_data,
    input  logic [2:0] lock_k,
    output logic       found,
    output logic [2:0] found_k,
`ifdef DSI_RX_SYNC_TOL_EN
    output logic       found_corr,
`endif
    output logic [7:0] aligned
);

    logic [7:0]  prev_byte;
    logic [15:0] win;
    logic [7:0]  exact_hit;
`ifdef DSI_RX_SYNC_TOL_EN
    logic [7:0]  near_hit;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            prev_byte <= '0;
        end else begin
            prev_byte <= ser_data;
        end
    end

    assign win = {prev_byte, ser_data};

    always_comb begin
        exact_hit = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            exact_hit[3'(i)] = sync_match(win, 3'(i));
        end
    end

`ifdef DSI_RX_SYNC_TOL_EN
    always_comb begin
        near_hit = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            near_hit[3'(i)] = sync_near(win, 3'(i));
        end
    end
`endif

    // Lowest offset wins; an exact hit anywhere outranks every 1-bit hit.
    always_comb begin
        found   = 1'b0;
        found_k = '0;
`ifdef DSI_RX_SYNC_TOL_EN
        found_corr = 1'b0;
`endif
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && exact_hit[3'(i)]) begin
                found   = 1'b1;
                found_k = 3'(i);
            end
        end
`ifdef DSI_RX_SYNC_TOL_EN
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && near_hit[3'(i)]) begin
                found      = 1'b1;
                found_k    = 3'(i);
                found_corr = 1'b1;
            end
        end
`endif
    end

    assign aligned = sync_cand(win, lock_k);

endmodule

// File: rtl/dsi_hs_lane_rx.sv
// MIPI D-PHY HS data lane receiver: settle, SoT sync search, offset lock, HS-trail strip.
// Optional DSI_RX_SYNC_TOL_EN: accept 1-bit-error sync leaders and report them on sot_corr.
module dsi_hs_lane_rx
    import dsi_phy_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SYNC_TIMEOUT  = 32,
    parameter int unsigned TRAIL_DROP    = 2
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       hs_en,
    input  logic [7:0] ser_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       sot_det,
    output logic       sot_err,
    output logic       eot,
`ifdef DSI_RX_SYNC_TOL_EN
    output logic       sot_corr,
`endif
    output logic       active
);

    localparam int unsigned STAGES       = TRAIL_DROP + 1;
    localparam logic [7:0]  SETTLE_LOAD  = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
    localparam logic [7:0]  TIMEOUT_LOAD = (SYNC_TIMEOUT > 0)  ? 8'(SYNC_TIMEOUT - 1)  : 8'd0;

    rx_state_t   state;
    logic [7:0]  cnt;
    logic [2:0]  offset_q;
    logic        found;
    logic [2:0]  found_k;
    logic [7:0]  aligned;
    logic        push;
    logic [7:0]  dl_byte [STAGES];
    logic [STAGES-1:0] dl_vld;
`ifdef DSI_RX_SYNC_TOL_EN
    logic        found_corr;
`endif

    dsi_rx_byte_aligner u_align (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .ser_data   (ser_data),
        .lock_k     (offset_q),
        .found      (found),
        .found_k    (found_k),
`ifdef DSI_RX_SYNC_TOL_EN
        .found_corr (found_corr),
`endif
        .aligned    (aligned)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            offset_q <= '0;
            sot_det  <= 1'b0;
            sot_err  <= 1'b0;
            eot      <= 1'b0;
            active   <= 1'b0;
`ifdef DSI_RX_SYNC_TOL_EN
            sot_corr <= 1'b0;
`endif
        end else begin
            sot_det <= 1'b0;
            sot_err <= 1'b0;
            eot     <= 1'b0;
`ifdef DSI_RX_SYNC_TOL_EN
            sot_corr <= 1'b0;
`endif
            if (!hs_en) begin
                state  <= IDLE;
                active <= 1'b0;
                if (state == ACTIVE) begin
                    eot <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state  <= SETTLE;
                        cnt    <= SETTLE_LOAD;
                        active <= 1'b1;
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            state <= SEARCH;
                            cnt   <= TIMEOUT_LOAD;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    SEARCH: begin
                        if (found) begin
                            state    <= ACTIVE;
                            offset_q <= found_k;
                            sot_det  <= 1'b1;
`ifdef DSI_RX_SYNC_TOL_EN
                            sot_corr <= found_corr;
`endif
                        end else if (cnt == '0) begin
                            state   <= ERR_WAIT;
                            sot_err <= 1'b1;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    ACTIVE, ERR_WAIT: begin
                        state <= state;
                    end
                    default: begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign push = (state == ACTIVE) && hs_en;

    // Bytes only move behind a valid entry, so out_data holds its last payload byte when idle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                dl_byte[i] <= '0;
            end
        end else if (!hs_en) begin
            dl_vld <= '0;
        end else begin
            dl_vld[0] <= push;
            if (push) begin
                dl_byte[0] <= aligned;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                if (dl_vld[i-1]) begin
                    dl_byte[i] <= dl_byte[i-1];
                end
            end
        end
    end

    assign out_data  = dl_byte[STAGES-1];
    assign out_valid = dl_vld[STAGES-1];

endmodule

// File: tb/tb_dsi_hs_lane_rx.sv
// Directed-vector bench for dsi_hs_lane_rx (SETTLE_CYCLES=4, SYNC_TIMEOUT=32, TRAIL_DROP=2).
// Builds with or without DSI_RX_SYNC_TOL_EN.
module tb_dsi_hs_lane_rx;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       hs_en;
    logic [7:0] ser_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       sot_det;
    logic       sot_err;
    logic       eot;
    logic       active;
`ifdef DSI_RX_SYNC_TOL_EN
    logic       sot_corr;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_sys = ~clk_sys;

    dsi_hs_lane_rx #(
        .SETTLE_CYCLES (4),
        .SYNC_TIMEOUT  (32),
        .TRAIL_DROP    (2)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .hs_en     (hs_en),
        .ser_data  (ser_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .sot_det   (sot_det),
        .sot_err   (sot_err),
        .eot       (eot),
`ifdef DSI_RX_SYNC_TOL_EN
        .sot_corr  (sot_corr),
`endif
        .active    (active)
    );

    // Inputs are applied, the edge samples them, and outputs are read 1 ns later.
    task automatic cyc(input logic [7:0] d, input logic h);
        ser_data = d;
        hs_en    = h;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        compared++;
        if ({out_data, out_valid, sot_det, sot_err, eot, active} !== 13'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {out_data, out_valid, sot_det, sot_err, eot, active});
        end
        compared++;
        if (dut.offset_q !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_offset: got %0d expected 0", dut.offset_q);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vd [16] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h1D,
                                8'h29, 8'h11, 8'h22, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_b [3] = '{8'h29, 8'h11, 8'h22};
        int nout = 0, nsot = 0, neot = 0, sot_idx = -1, eot_idx = -1;
        // Offset 0 reads the previous byte, so hs_en stays high one byte past the last trail byte.
        for (int i = 0; i < 16; i++) begin
            cyc(vd[i], i < 14);
            if (out_valid) begin
                compared++;
                if (nout >= 3) begin
                    mismatched++;
                    $display("FAIL basic_extra_out: got %h at idx %0d expected no valid", out_data, i);
                end else if (out_data !== exp_b[nout] || i != 11 + nout) begin
                    mismatched++;
                    $display("FAIL basic_out: got %h at idx %0d expected %h at idx %0d",
                             out_data, i, exp_b[nout], 11 + nout);
                end
                nout++;
            end
            if (sot_det) begin nsot++; sot_idx = i; end
            if (eot) begin neot++; eot_idx = i; end
        end
        compared++;
        if (nout != 3) begin
            mismatched++;
            $display("FAIL basic_out_count: got %0d expected 3", nout);
        end
        compared++;
        if (nsot != 1 || sot_idx != 8) begin
            mismatched++;
            $display("FAIL basic_sot: got %0d pulses at idx %0d expected 1 at idx 8", nsot, sot_idx);
        end
        compared++;
        if (neot != 1 || eot_idx != 14) begin
            mismatched++;
            $display("FAIL basic_eot: got %0d pulses at idx %0d expected 1 at idx 14", neot, eot_idx);
        end
        compared++;
        if (active !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_idle: got active=%b expected 0", active);
        end
    endtask

    task automatic test_offset3();
        // bits: 000 00011101 11000011 00000...
        logic [7:0] vd [15] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'hB8,
                                8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        int nvalid = 0, first_idx = -1, sot_idx = -1;
        logic [7:0] first_byte = '0;
        for (int i = 0; i < 15; i++) begin
            cyc(vd[i], i < 13);
            if (out_valid) begin
                if (nvalid == 0) begin first_idx = i; first_byte = out_data; end
                nvalid++;
            end
            if (sot_det) sot_idx = i;
        end
        compared++;
        if (sot_idx != 7) begin
            mismatched++;
            $display("FAIL off3_sot: got idx %0d expected idx 7", sot_idx);
        end
        compared++;
        if (dut.offset_q !== 3'd3) begin
            mismatched++;
            $display("FAIL off3_lock: got %0d expected 3", dut.offset_q);
        end
        compared++;
        if (first_byte !== 8'hC3 || first_idx != 10) begin
            mismatched++;
            $display("FAIL off3_data: got %h at idx %0d expected c3 at idx 10", first_byte, first_idx);
        end
        compared++;
        if (nvalid != 3) begin
            mismatched++;
            $display("FAIL off3_count: got %0d expected 3", nvalid);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 40; i++) begin
            cyc(8'h00, 1'b1);
            compared++;
            if (sot_err !== (i == 36) || out_valid !== 1'b0 || sot_det !== 1'b0) begin
                mismatched++;
                $display("FAIL timeout_cycle%0d: got err=%b valid=%b det=%b expected err=%b valid=0 det=0",
                         i, sot_err, out_valid, sot_det, (i == 36));
            end
        end
        compared++;
        if (active !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_errwait: got active=%b expected 1", active);
        end
        cyc(8'h00, 1'b0);
        compared++;
        if (active !== 1'b0 || eot !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_idle: got active=%b eot=%b expected 0 0", active, eot);
        end
    endtask

    task automatic test_drop();
        logic [7:0] vd [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1D,
                                8'h29, 8'h11, 8'h22, 8'h33, 8'h00};
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b0);
        compared++;
        if ({sot_det, sot_err, eot, active, out_valid} !== 5'b0) begin
            mismatched++;
            $display("FAIL settle_drop: got det/err/eot/act/vld=%b expected 00000",
                     {sot_det, sot_err, eot, active, out_valid});
        end
        cyc(8'h00, 1'b0);
        for (int i = 0; i < 13; i++) begin
            cyc(vd[i], i < 12);
            if (i == 11) begin
                compared++;
                if (out_valid !== 1'b1 || out_data !== 8'h29) begin
                    mismatched++;
                    $display("FAIL drop_first: got valid=%b data=%h expected 1 29", out_valid, out_data);
                end
            end
        end
        compared++;
        if (eot !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h29) begin
            mismatched++;
            $display("FAIL active_drop: got eot=%b valid=%b data=%h expected 1 0 29", eot, out_valid, out_data);
        end
        cyc(8'h00, 1'b1);
        compared++;
        if (active !== 1'b1 || eot !== 1'b0 || dut.state !== dsi_phy_pkg::SETTLE) begin
            mismatched++;
            $display("FAIL restart: got active=%b eot=%b state=%0d expected 1 0 %0d",
                     active, eot, dut.state, dsi_phy_pkg::SETTLE);
        end
        cyc(8'h00, 1'b0);
        compared++;
        if (eot !== 1'b0 || active !== 1'b0) begin
            mismatched++;
            $display("FAIL restart_drop: got eot=%b active=%b expected 0 0", eot, active);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] vd [15] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1D,
                                8'h29, 8'h11, 8'h22, 8'hFF, 8'hFF, 8'h00, 8'h00};
        int sot_idx = -1, first_idx = -1;
        logic [7:0] first_byte = '0;
        for (int i = 0; i < 13; i++) cyc(vd[i], 1'b1);
        compared++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            mismatched++;
            $display("FAIL pre_reset: got valid=%b data=%h expected 1 11", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        hs_en = 1'b0;
        #1;
        compared++;
        if ({out_data, out_valid, sot_det, sot_err, eot, active} !== 13'h0) begin
            mismatched++;
            $display("FAIL async_reset: got %h expected 0000",
                     {out_data, out_valid, sot_det, sot_err, eot, active});
        end
        @(posedge clk_sys);
        #1;
        compared++;
        if (eot !== 1'b0 || active !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_no_eot: got eot=%b active=%b expected 0 0", eot, active);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        for (int i = 0; i < 15; i++) begin
            cyc(vd[i], i < 14);
            if (sot_det) sot_idx = i;
            if (out_valid && first_idx < 0) begin first_idx = i; first_byte = out_data; end
        end
        compared++;
        if (sot_idx != 8 || first_idx != 11 || first_byte !== 8'h29) begin
            mismatched++;
            $display("FAIL post_reset_sync: got sot idx %0d first %h at idx %0d expected 8 29 11",
                     sot_idx, first_byte, first_idx);
        end
    endtask

    task automatic test_tolerance();
        for (int i = 0; i < 40; i++) begin
            cyc((i == 7) ? 8'h1C : 8'h00, 1'b1);
`ifdef DSI_RX_SYNC_TOL_EN
            compared++;
            if (sot_det !== (i == 8) || sot_corr !== (i == 8) || sot_err !== 1'b0) begin
                mismatched++;
                $display("FAIL tol_cycle%0d: got det=%b corr=%b err=%b expected %b %b 0",
                         i, sot_det, sot_corr, sot_err, (i == 8), (i == 8));
            end
`else
            compared++;
            if (sot_err !== (i == 36) || sot_det !== 1'b0) begin
                mismatched++;
                $display("FAIL notol_cycle%0d: got err=%b det=%b expected %b 0",
                         i, sot_err, sot_det, (i == 36));
            end
`endif
        end
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        hs_en    = 1'b0;
        ser_data = 8'h00;
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        cyc(8'h00, 1'b0);
        test_basic();
        test_offset3();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_tolerance();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
